// File: rtl/pcie_tx_pkg.sv
// pcie_tx_pkg
// Shared definitions for the PCIe transmit arbiter slice.
//   TLP_W    : width of one transmit beat (64-bit AXI stream to the core)
//   NREQ_MAX : largest supported requester count
//   PTR_W    : width of a round-robin pointer able to address NREQ_MAX requesters
//   state_e  : arbiter FSM states
// Optional feature macro used by this slice: PCIE_TX_ARB_PRIORITY_EN
// (strict priority for requester 0, see pcie_tx_arbiter).
package pcie_tx_pkg;

    localparam int TLP_W    = 64;
    localparam int NREQ_MAX = 8;
    localparam int PTR_W    = $clog2(NREQ_MAX);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

endpackage

// File: rtl/pcie_rr_pick.sv
// pcie_rr_pick
// Combinational round-robin picker. Searches req_i starting at index ptr_i,
// wrapping from NREQ-1 back to 0, and returns the first set bit as a one-hot
// winner.
// Ports:
//   req_i    in  NREQ   request mask
//   ptr_i    in  PTR_W  search start index (must be < NREQ)
//   winner_o out NREQ   one-hot winner, zero when nothing requested
//   found_o  out 1      any request present
module pcie_rr_pick
    import pcie_tx_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  winner_o,
    output logic             found_o
);

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [NREQ-1:0]   rot_req;
    logic [NREQ-1:0]   rot_win;
    logic [2*NREQ-1:0] win_dbl;

    // Rotate the mask right by the pointer so the search always starts at
    // bit 0; the doubled vector supplies the wrapped-around bits.
    assign rot_req = NREQ'({req_i, req_i} >> ptr_i);

    // Isolate the lowest set bit of the rotated mask.
    assign rot_win = rot_req & (~rot_req + ONE);

    // Rotate the winner back left by the pointer into requester numbering.
    assign win_dbl  = {{NREQ{1'b0}}, rot_win} << ptr_i;
    assign winner_o = win_dbl[NREQ-1:0] | win_dbl[2*NREQ-1:NREQ];
    assign found_o  = |req_i;

endmodule

// File: rtl/pcie_tx_arbiter.sv
// pcie_tx_arbiter
// Packet-level arbiter sharing the PCIe core transmit AXI stream between
// NREQ TLP sources (index 0 is the completion generator). A grant is held
// from the first beat of a packet through its tlast beat, so TLPs never
// interleave. Requesters are served round-robin.
// Optional feature: define PCIE_TX_ARB_PRIORITY_EN to give requester 0
// strict priority at every arbitration; the others stay round-robin.
// Ports:
//   clock             in  1        core user clock
//   reset_n           in  1        asynchronous active-low reset
//   req_tdata         in  NREQ*64  requester i on [64*i+63:64*i]
//   req_1dw           in  NREQ     beat carries only the low DW
//   req_tlast         in  NREQ     last beat of TLP
//   req_tvalid        in  NREQ     beat valid
//   req_tready        out NREQ     beat accepted (only the owner sees tready)
//   s_axis_tx_tdata   out 64       to core
//   s_axis_tx_1dw     out 1        to core
//   s_axis_tx_tlast   out 1        to core
//   s_axis_tx_tvalid  out 1        to core
//   s_axis_tx_tready  in  1        from core
//   grant             out NREQ     one-hot current owner, zero when idle
//   busy              out 1        a packet is owned
module pcie_tx_arbiter
    import pcie_tx_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREQ*TLP_W-1:0] req_tdata,
    input  logic [NREQ-1:0]       req_1dw,
    input  logic [NREQ-1:0]       req_tlast,
    input  logic [NREQ-1:0]       req_tvalid,
    output logic [NREQ-1:0]       req_tready,
    output logic [TLP_W-1:0]      s_axis_tx_tdata,
    output logic                  s_axis_tx_1dw,
    output logic                  s_axis_tx_tlast,
    output logic                  s_axis_tx_tvalid,
    input  logic                  s_axis_tx_tready,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]  ptr_q,   ptr_d;

    logic              in_xfer;
    logic [TLP_W-1:0]  req_data [NREQ];
    logic [TLP_W-1:0]  mux_data;
    logic              mux_1dw;
    logic              mux_last;
    logic              mux_valid;
    logic              last_hs;

    logic [PTR_W-1:0]  gidx;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [PTR_W-1:0]  pick_ptr;
    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   pick_req;
    logic [NREQ-1:0]   pick_win;
    logic              pick_found;
    logic [NREQ-1:0]   arb_win;
    logic              arb_found;

    assign in_xfer = (state_q == XFER);

    // ------------------------------------------------------------------
    // Data path: one-hot AND-OR mux driven straight from the grant register
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_data[gi] = req_tdata[TLP_W*gi +: TLP_W];
    end

    always_comb begin
        mux_data  = '0;
        mux_1dw   = 1'b0;
        mux_last  = 1'b0;
        mux_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            mux_data  = mux_data  | (req_data[i] & {TLP_W{grant_q[i]}});
            mux_1dw   = mux_1dw   | (req_1dw[i]    & grant_q[i]);
            mux_last  = mux_last  | (req_tlast[i]  & grant_q[i]);
            mux_valid = mux_valid | (req_tvalid[i] & grant_q[i]);
        end
    end

    assign s_axis_tx_tdata  = mux_data;
    assign s_axis_tx_1dw    = mux_1dw;
    assign s_axis_tx_tlast  = mux_last;
    assign s_axis_tx_tvalid = in_xfer & mux_valid;
    assign req_tready       = grant_q & {NREQ{in_xfer & s_axis_tx_tready}};

    assign last_hs = s_axis_tx_tvalid & s_axis_tx_tready & mux_last;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Index of the current owner, and the pointer that follows it.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                gidx = PTR_W'(i);
            end
        end
    end

    assign ptr_nxt = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);

    // On the finishing beat the owner's tvalid still shows the beat being
    // consumed, so it is masked out of the re-arbitration.
    assign arb_req  = in_xfer ? (req_tvalid & ~grant_q) : req_tvalid;
    assign pick_ptr = in_xfer ? ptr_nxt : ptr_q;

`ifdef PCIE_TX_ARB_PRIORITY_EN
    localparam logic [NREQ-1:0] REQ0 = NREQ'(1);

    // Requester 0 bypasses the picker; the rest rotate among themselves.
    assign pick_req  = arb_req & ~REQ0;
    assign arb_win   = arb_req[0] ? REQ0 : pick_win;
    assign arb_found = arb_req[0] | pick_found;
`else
    assign pick_req  = arb_req;
    assign arb_win   = pick_win;
    assign arb_found = pick_found;
`endif

    pcie_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i    (pick_req),
        .ptr_i    (pick_ptr),
        .winner_o (pick_win),
        .found_o  (pick_found)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_win;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (last_hs) begin
                    ptr_d = ptr_nxt;
                    if (arb_found) begin
                        grant_d = arb_win;
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = in_xfer;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// tb_pcie_tx_arbiter
// Directed self-checking bench for pcie_tx_arbiter (NREQ = 3).
// Each requester is fed from a small beat memory that advances when the
// arbiter accepts a beat; inputs change 1 ns after the rising edge and
// outputs are checked on the falling edge. The priority scenario is only
// compiled when PCIE_TX_ARB_PRIORITY_EN is defined.
module tb_pcie_tx_arbiter;

    localparam int NREQ = 3;

    logic                clock;
    logic                reset_n;
    logic [NREQ*64-1:0]  req_tdata;
    logic [NREQ-1:0]     req_1dw;
    logic [NREQ-1:0]     req_tlast;
    logic [NREQ-1:0]     req_tvalid;
    logic [NREQ-1:0]     req_tready;
    logic [63:0]         s_axis_tx_tdata;
    logic                s_axis_tx_1dw;
    logic                s_axis_tx_tlast;
    logic                s_axis_tx_tvalid;
    logic                s_axis_tx_tready;
    logic [NREQ-1:0]     grant;
    logic                busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] d;
        logic        last;
        logic        dw1;
    } beat_t;

    beat_t src_mem [NREQ][16];
    int    src_wr  [NREQ];
    int    src_rd  [NREQ];

    pcie_tx_arbiter #(
        .NREQ (NREQ)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_tdata        (req_tdata),
        .req_1dw          (req_1dw),
        .req_tlast        (req_tlast),
        .req_tvalid       (req_tvalid),
        .req_tready       (req_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_1dw    (s_axis_tx_1dw),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .s_axis_tx_tready (s_axis_tx_tready),
        .grant            (grant),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Recognisable beat payload: requester and beat number in both halves.
    function automatic logic [63:0] beat(input int r, input int b);
        return {16'hC0DE, 8'(r), 8'(b), 16'hD00D, 8'(r), 8'(b)};
    endfunction

    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
    endtask

    task automatic push(input int r, input int b, input logic last, input logic dw1);
        src_mem[r][src_wr[r]] = '{d: beat(r, b), last: last, dw1: dw1};
        src_wr[r]++;
    endtask

    task automatic drive_src();
        for (int i = 0; i < NREQ; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                req_tvalid[i]          = 1'b1;
                req_tdata[64*i +: 64]  = src_mem[i][src_rd[i]].d;
                req_tlast[i]           = src_mem[i][src_rd[i]].last;
                req_1dw[i]             = src_mem[i][src_rd[i]].dw1;
            end else begin
                req_tvalid[i]          = 1'b0;
                req_tdata[64*i +: 64]  = '0;
                req_tlast[i]           = 1'b0;
                req_1dw[i]             = 1'b0;
            end
        end
    endtask

    // Called at a falling edge; advances one cycle, consuming accepted beats,
    // applies the next core tready, and returns at the next falling edge.
    task automatic tick(input logic tr);
        logic [NREQ-1:0] hs;
        hs = req_tvalid & req_tready;
        @(posedge clock);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) src_rd[i]++;
        end
        s_axis_tx_tready = tr;
        drive_src();
        @(negedge clock);
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        clear_src();
        drive_src();
        s_axis_tx_tready = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n          = 1'b0;
        s_axis_tx_tready = 1'b1;
        clear_src();
        drive_src();
        @(negedge clock);
        checks++;
        if (grant !== 3'b000) begin
            errors++; $display("FAIL reset_grant: got %b expected 000", grant);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (s_axis_tx_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid: got %b expected 0", s_axis_tx_tvalid);
        end
        checks++;
        if (req_tready !== 3'b000) begin
            errors++; $display("FAIL reset_req_tready: got %b expected 000", req_tready);
        end
        reset_n = 1'b1;
        @(negedge clock);
        $display("test_reset done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        push(1, 0, 1'b0, 1'b0);
        push(1, 1, 1'b0, 1'b0);
        push(1, 2, 1'b1, 1'b0);
        drive_src();
        checks++;
        if (grant !== 3'b000) begin
            errors++; $display("FAIL single_no_grant_yet: got %b expected 000", grant);
        end
        for (int b = 0; b < 3; b++) begin
            tick(1'b1);
            checks++;
            if (grant !== 3'b010 || busy !== 1'b1 || s_axis_tx_tvalid !== 1'b1) begin
                errors++;
                $display("FAIL single_grant beat%0d: got grant=%b busy=%b tvalid=%b expected 010/1/1",
                         b, grant, busy, s_axis_tx_tvalid);
            end
            checks++;
            if (s_axis_tx_tdata !== beat(1, b) || s_axis_tx_tlast !== (b == 2)) begin
                errors++;
                $display("FAIL single_data beat%0d: got %h last=%b expected %h last=%b",
                         b, s_axis_tx_tdata, s_axis_tx_tlast, beat(1, b), (b == 2));
            end
            checks++;
            if (req_tready !== 3'b010) begin
                errors++; $display("FAIL single_req_tready beat%0d: got %b expected 010", b, req_tready);
            end
        end
        tick(1'b1);
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0 || s_axis_tx_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got grant=%b busy=%b tvalid=%b expected 000/0/0",
                     grant, busy, s_axis_tx_tvalid);
        end
        $display("test_single done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_contention();
        logic [2:0] exp_g;
        reset_dut();
        for (int r = 0; r < NREQ; r++) begin
            push(r, 0, 1'b0, 1'b0);
            push(r, 1, 1'b1, 1'b0);
        end
        drive_src();
        for (int k = 0; k < 6; k++) begin
            tick(1'b1);
            exp_g = 3'b001 << (k / 2);
            checks++;
            if (grant !== exp_g || s_axis_tx_tvalid !== 1'b1 ||
                s_axis_tx_tdata !== beat(k / 2, k % 2)) begin
                errors++;
                $display("FAIL contention beat%0d: got grant=%b tvalid=%b data=%h expected %b/1/%h",
                         k, grant, s_axis_tx_tvalid, s_axis_tx_tdata, exp_g, beat(k / 2, k % 2));
            end
        end
        tick(1'b1);
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            errors++; $display("FAIL contention_idle: got grant=%b busy=%b expected 000/0", grant, busy);
        end
        $display("test_contention done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        logic tr_seq [7];
        int   exp_b  [6];
        clear_src();
        tr_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_b  = '{0, 1, 1, 1, 2, 3};
        for (int b = 0; b < 4; b++) push(0, b, (b == 3), 1'b0);
        push(2, 0, 1'b1, 1'b0);
        drive_src();
        for (int k = 0; k < 6; k++) begin
            tick(tr_seq[k]);
            checks++;
            if (grant !== 3'b001 || s_axis_tx_tdata !== beat(0, exp_b[k]) ||
                s_axis_tx_tlast !== (k == 5)) begin
                errors++;
                $display("FAIL bp_data cyc%0d: got grant=%b data=%h last=%b expected 001/%h/%b",
                         k, grant, s_axis_tx_tdata, s_axis_tx_tlast, beat(0, exp_b[k]), (k == 5));
            end
            checks++;
            if (req_tready !== {2'b00, tr_seq[k]}) begin
                errors++;
                $display("FAIL bp_req_tready cyc%0d: got %b expected %b", k, req_tready, {2'b00, tr_seq[k]});
            end
        end
        tick(tr_seq[6]);
        checks++;
        if (grant !== 3'b100 || s_axis_tx_tdata !== beat(2, 0)) begin
            errors++;
            $display("FAIL bp_next_owner: got grant=%b data=%h expected 100/%h", grant, s_axis_tx_tdata, beat(2, 0));
        end
        tick(1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL bp_idle: got busy=%b expected 0", busy);
        end
        $display("test_backpressure done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        clear_src();
        for (int b = 0; b < 4; b++) push(0, b, (b == 3), 1'b0);
        drive_src();
        tick(1'b1);
        tick(1'b1);
        checks++;
        if (grant !== 3'b001 || s_axis_tx_tdata !== beat(0, 1)) begin
            errors++;
            $display("FAIL rstmid_before: got grant=%b data=%h expected 001/%h", grant, s_axis_tx_tdata, beat(0, 1));
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (s_axis_tx_tvalid !== 1'b0 || grant !== 3'b000 || busy !== 1'b0 || req_tready !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_assert: got tvalid=%b grant=%b busy=%b req_tready=%b expected 0/000/0/000",
                     s_axis_tx_tvalid, grant, busy, req_tready);
        end
        clear_src();
        push(2, 0, 1'b1, 1'b0);
        drive_src();
        @(negedge clock);
        reset_n = 1'b1;
        tick(1'b1);
        checks++;
        if (grant !== 3'b100 || s_axis_tx_tdata !== beat(2, 0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after: got grant=%b data=%h busy=%b expected 100/%h/1",
                     grant, s_axis_tx_tdata, busy, beat(2, 0));
        end
        tick(1'b1);
        $display("test_reset_mid done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_wrap();
        clear_src();
        push(1, 0, 1'b1, 1'b0);
        drive_src();
        tick(1'b1);
        tick(1'b1);
        // Pointer now sits at 2; requesters 0 and 2 request together.
        clear_src();
        push(0, 0, 1'b1, 1'b1);
        push(2, 0, 1'b1, 1'b0);
        drive_src();
        tick(1'b1);
        checks++;
        if (grant !== 3'b100 || s_axis_tx_1dw !== 1'b0) begin
            errors++; $display("FAIL wrap_first: got grant=%b 1dw=%b expected 100/0", grant, s_axis_tx_1dw);
        end
        tick(1'b1);
        checks++;
        if (grant !== 3'b001 || s_axis_tx_1dw !== 1'b1 || s_axis_tx_tdata !== beat(0, 0)) begin
            errors++;
            $display("FAIL wrap_second: got grant=%b 1dw=%b data=%h expected 001/1/%h",
                     grant, s_axis_tx_1dw, s_axis_tx_tdata, beat(0, 0));
        end
        tick(1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL wrap_idle: got busy=%b expected 0", busy);
        end
        $display("test_wrap done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [2:0] exp_g [3];
        int         exp_b [3];
        reset_dut();
        exp_g = '{3'b001, 3'b010, 3'b001};
        exp_b = '{0, 0, 1};
        push(0, 0, 1'b1, 1'b0);
        push(0, 1, 1'b1, 1'b0);
        push(1, 0, 1'b1, 1'b0);
        drive_src();
        for (int k = 0; k < 3; k++) begin
            tick(1'b1);
            checks++;
            if (grant !== exp_g[k] || s_axis_tx_tdata !== beat((k == 1) ? 1 : 0, exp_b[k])) begin
                errors++;
                $display("FAIL b2b pkt%0d: got grant=%b data=%h expected %b/%h",
                         k, grant, s_axis_tx_tdata, exp_g[k], beat((k == 1) ? 1 : 0, exp_b[k]));
            end
        end
        tick(1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: got busy=%b expected 0", busy);
        end
        $display("test_back_to_back done");
    endtask

`ifdef PCIE_TX_ARB_PRIORITY_EN
    // ------------------------------------------------------------------
    task automatic test_priority();
        reset_dut();
        push(1, 0, 1'b0, 1'b0);
        push(1, 1, 1'b1, 1'b0);
        push(2, 0, 1'b0, 1'b0);
        push(2, 1, 1'b1, 1'b0);
        drive_src();
        tick(1'b1);
        checks++;
        if (grant !== 3'b010) begin
            errors++; $display("FAIL prio_first: got grant=%b expected 010", grant);
        end
        push(0, 0, 1'b1, 1'b1);
        drive_src();
        tick(1'b1);
        tick(1'b1);
        checks++;
        if (grant !== 3'b001 || s_axis_tx_1dw !== 1'b1 || s_axis_tx_tdata !== beat(0, 0)) begin
            errors++;
            $display("FAIL prio_cpl: got grant=%b 1dw=%b data=%h expected 001/1/%h",
                     grant, s_axis_tx_1dw, s_axis_tx_tdata, beat(0, 0));
        end
        tick(1'b1);
        checks++;
        if (grant !== 3'b100) begin
            errors++; $display("FAIL prio_after: got grant=%b expected 100", grant);
        end
        tick(1'b1);
        tick(1'b1);
        $display("test_priority done");
    endtask
`endif

    initial begin
        reset_n          = 1'b0;
        s_axis_tx_tready = 1'b1;
        req_tdata        = '0;
        req_1dw          = '0;
        req_tlast        = '0;
        req_tvalid       = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
`ifdef PCIE_TX_ARB_PRIORITY_EN
        test_priority();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Packet-level arbiter sharing the single PCIe core transmit AXI stream between NREQ TLP sources: completion generator, DMA write engine, DMA read-request engine. Sits between those engines and the core wrapper's s_axis_tx_* port, in the user clock domain. A grant is held from a packet's first beat through its tlast beat, so TLPs are never interleaved. Requesters are served round-robin, with optional strict priority for completions.

## Interface
- NREQ, 3: number of requesters, 2..8; index 0 is the completion source.
- clock  in  1  core user clock
- reset_n  in  1  asynchronous active-low reset
- req_tdata  in  NREQ*64  per-requester beat data; requester i occupies [64*i+63:64*i]
- req_1dw  in  NREQ  per-requester: beat carries only the low DW
- req_tlast  in  NREQ  per-requester last beat of TLP
- req_tvalid  in  NREQ  per-requester beat valid
- req_tready  out  NREQ  per-requester beat accepted
- s_axis_tx_tdata  out  64  to core
- s_axis_tx_1dw  out  1  to core
- s_axis_tx_tlast  out  1  to core
- s_axis_tx_tvalid  out  1  to core
- s_axis_tx_tready  in  1  from core
- grant  out  NREQ  one-hot current owner; zero when idle
- busy  out  1  high while a packet is owned

## Operation
- States: IDLE, XFER.
- IDLE:
  - If any req_tvalid, pick a winner with the round-robin picker and register it into grant. Enter XFER on the next cycle.
  - Outputs are not driven valid in IDLE.
- XFER:
  - s_axis_tx_* mirror the granted requester's signals.
  - req_tready[g] = s_axis_tx_tready; every other req_tready is 0.
- Beat handshake: tvalid & tready, the AXI rule. The requester must hold its data while tready is low. The arbiter adds no storage.
- Last beat (handshake with tlast):
  - Pointer becomes g+1 mod NREQ.
  - If any other request is valid in the same cycle, re-arbitrate immediately (masking the finishing requester's current tvalid as stale). The new grant is registered and XFER continues with no idle cycle.
  - Otherwise go to IDLE.
- Round-robin search: start at the pointer, wrap NREQ-1 to 0, take the first valid.
- Requester deasserting tvalid mid-packet: grant is held, bubbles pass to the core, there is no timeout.
- Reset (async assert): state IDLE, grant 0, pointer 0, busy 0, all req_tready 0, s_axis_tx_tvalid 0. A packet truncated by reset is abandoned. Upstream also resets the core on pci_reset.

## Timing
- IDLE to first beat offered: 1 cycle after tvalid is seen (grant registered).
- Back-to-back packets from different requesters: zero idle cycles.
- The same requester following its own packet while others are pending is served after them.
- Data path: combinational mux from grant register to s_axis_tx_*, no added latency.
- req_tready is combinational from s_axis_tx_tready; core tready is registered inside the core.
- busy = (state == XFER), registered.

## Configuration
- PCIE_TX_ARB_PRIORITY_EN defined: at each arbitration, requester 0 wins whenever its tvalid is high, regardless of pointer. Other requesters are served round-robin among themselves. This bounds completion latency to one packet.
- Undefined: pure round-robin over all NREQ, requester 0 included.

## Structure
- Shared package pcie_tx_pkg:
  - TLP_W = 64
  - state enum {IDLE, XFER}
  - NREQ_MAX = 8
- Sub-module pcie_rr_pick: combinational; inputs req mask and pointer; outputs one-hot winner and a found flag. It is instantiated once; the priority override is applied around it.

## Test plan
- Single requester: requester 1 sends a 3-beat TLP with tready always 1. Expected: grant=3'b010 one cycle after tvalid; 3 beats out unchanged; tlast on beat 3; back to IDLE, busy 0.
- Contention: all three assert 2-beat TLPs together, no priority macro, pointer 0. Expected order 0, 1, 2 with no idle cycles between packets; six consecutive valid beats.
- Backpressure: tready toggles 1,0,0,1 during a 4-beat TLP. Expected: data held stable while tready=0; req_tready mirrors tready; other requesters see tready 0 throughout.
- Priority (PCIE_TX_ARB_PRIORITY_EN): requesters 1 and 2 stream continuously; requester 0 raises a 1dw completion mid-packet of requester 1. Expected: requester 0 is granted immediately after that tlast, with s_axis_tx_1dw=1 on its beat.
- Reset mid-packet: reset_n is asserted on beat 2 of 4. Expected: same cycle, tvalid 0, grant 0, busy 0. After release with only requester 2 valid, grant=3'b100.
- Wrap: NREQ=3, pointer at 2, requesters 0 and 2 valid. Expected: 2 granted first, then 0.
